// File: rtl/mem_trans_pkg.sv
// Shared constants and types for the transition-counter memory.
package mem_trans_pkg;

  localparam int unsigned CNTR_DEFAULT   = 3;
  localparam int unsigned ADDR_W_DEFAULT = 2;
  localparam int unsigned DATA_W_DEFAULT = 32;

  localparam logic [DATA_W_DEFAULT-1:0] CNT_MAX = {DATA_W_DEFAULT{1'b1}};

  typedef logic [DATA_W_DEFAULT-1:0] cnt_t;

endpackage

// File: rtl/mem_trans_if.sv
// Control bus of the transition-counter memory: address, read/write select and probes.
interface mem_trans_if
  import mem_trans_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned NUM_CNTR = CNTR_DEFAULT
) ();

  logic [ADDR_W-1:0]   dir;
  logic                le;
  logic [NUM_CNTR-1:0] probe;

  modport master (output dir, output le, output probe);
  modport slave  (input dir, input le, input probe);

endinterface

// File: rtl/trans_cell.sv
// One transition counter: probe history, toggle detect, saturating increment, load mux.
module trans_cell #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              probe,
  input  logic              ld,
  input  logic [DATA_W-1:0] ld_val,
  output logic [DATA_W-1:0] cnt
);

  logic hist;
  logic toggle;
  logic at_max;

  assign toggle = probe ^ hist;
  assign at_max = (cnt == {DATA_W{1'b1}});

  // History always tracks probe; a load overrides any increment in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= 1'b0;
      cnt  <= '0;
    end else begin
      hist <= probe;
      if (ld) begin
        cnt <= ld_val;
      end else if (arm && toggle && !at_max) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_trans.sv
// Transition-counter memory for switching-activity estimation. Test builds only.
module mem_trans
  import mem_trans_pkg::*;
#(
  parameter int unsigned NUM_CNTR = CNTR_DEFAULT,
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W   = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  mem_trans_if.slave        bus,
  // Bidirectional data stays a module port so the tri-state resolves at this boundary.
  inout  wire  [DATA_W-1:0] dato
);

  logic                arm;
  logic [NUM_CNTR-1:0] ld;
  logic [DATA_W-1:0]   rd_data;
  logic [DATA_W-1:0]   cnt_arr [NUM_CNTR];

  // The first edge after reset only captures probe history; counting starts after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm <= 1'b0;
    end else begin
      arm <= 1'b1;
    end
  end

  // Write decode; out-of-range addresses match no counter and are dropped.
  always_comb begin
    ld = '0;
    for (int unsigned i = 0; i < NUM_CNTR; i++) begin
      if (!bus.le && (bus.dir == ADDR_W'(i))) begin
        ld[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CNTR; g++) begin : g_cell
    trans_cell #(
      .DATA_W (DATA_W)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .arm    (arm),
      .probe  (bus.probe[g]),
      .ld     (ld[g]),
      .ld_val (dato),
      .cnt    (cnt_arr[g])
    );
  end

  // Read mux; out-of-range addresses read zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_CNTR; i++) begin
      if (bus.dir == ADDR_W'(i)) begin
        rd_data = cnt_arr[i];
      end
    end
  end

  // Drive only while reading and out of reset; otherwise the bus belongs to the writer.
  assign dato = (bus.le && rst) ? rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_trans.sv
// Directed bench for mem_trans: reset, writes, toggle counting, collisions, saturation.
module tb_mem_trans;
  import mem_trans_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  wire  [31:0] dato;
  logic       tb_drv;
  cnt_t       tb_val;
  int         n_vec = 0;
  int         n_err = 0;

  mem_trans_if #(.ADDR_W(2), .NUM_CNTR(3)) bus ();

  assign dato = tb_drv ? tb_val : 'z;

  mem_trans #(
    .NUM_CNTR (3),
    .ADDR_W   (2),
    .DATA_W   (32)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .dato (dato)
  );

  always #5 clk = ~clk;

  // Combinational read; called away from the rising edge.
  task automatic read_cnt(input logic [1:0] a, output cnt_t v);
    bus.dir = a;
    bus.le  = 1'b1;
    #1;
    v = dato;
  endtask

  // One-cycle write; obs is the bus value seen while the bench drives it.
  task automatic write_cnt(input logic [1:0] a, input cnt_t d, output cnt_t obs);
    @(negedge clk);
    bus.le  = 1'b0;
    bus.dir = a;
    tb_val  = d;
    tb_drv  = 1'b1;
    #1;
    obs = dato;
    @(posedge clk);
    @(negedge clk);
    bus.le = 1'b1;
    tb_drv = 1'b0;
  endtask

  task automatic toggle(input logic [2:0] mask);
    @(negedge clk);
    bus.probe = bus.probe ^ mask;
    @(posedge clk);
  endtask

  task automatic test_reset();
    cnt_t v;
    rst       = 1'b0;
    bus.le    = 1'b1;
    bus.dir   = 2'd0;
    bus.probe = 3'b101;
    tb_drv    = 1'b1;
    tb_val    = 32'hA5A5_A5A5;
    #12;
    v = dato;
    n_vec++;
    if (v !== 32'hA5A5_A5A5) begin
      n_err++;
      $display("FAIL reset_release: got %h want %h", v, 32'hA5A5_A5A5);
    end
    tb_drv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      read_cnt(2'(i), v);
      n_vec++;
      if (v !== 32'd0) begin
        n_err++;
        $display("FAIL reset_cnt%0d: got %h want %h", i, v, 32'd0);
      end
    end
  endtask

  task automatic test_clear_write();
    cnt_t v;
    cnt_t obs;
    for (int i = 0; i < 3; i++) begin
      write_cnt(2'(i), 32'h1234_0000 + i, obs);
      n_vec++;
      if (obs !== 32'h1234_0000 + i) begin
        n_err++;
        $display("FAIL write_release%0d: got %h want %h", i, obs, 32'h1234_0000 + i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      read_cnt(2'(i), v);
      n_vec++;
      if (v !== 32'h1234_0000 + i) begin
        n_err++;
        $display("FAIL preload%0d: got %h want %h", i, v, 32'h1234_0000 + i);
      end
    end
    for (int i = 0; i < 3; i++) write_cnt(2'(i), 32'd0, obs);
    for (int i = 0; i < 3; i++) begin
      read_cnt(2'(i), v);
      n_vec++;
      if (v !== 32'd0) begin
        n_err++;
        $display("FAIL clear%0d: got %h want %h", i, v, 32'd0);
      end
    end
  endtask

  task automatic test_toggle_count();
    cnt_t v;
    cnt_t exp_v [3];
    exp_v = '{32'd0, 32'd10, 32'd0};
    repeat (10) toggle(3'b010);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      read_cnt(2'(i), v);
      n_vec++;
      if (v !== exp_v[i]) begin
        n_err++;
        $display("FAIL toggle_cnt%0d: got %0d want %0d", i, v, exp_v[i]);
      end
    end
  endtask

  task automatic test_collision();
    cnt_t v;
    cnt_t obs;
    write_cnt(2'd2, 32'd100, obs);
    read_cnt(2'd2, v);
    n_vec++;
    if (v !== 32'd100) begin
      n_err++;
      $display("FAIL coll_preload: got %0d want %0d", v, 100);
    end
    @(negedge clk);
    bus.le    = 1'b0;
    bus.dir   = 2'd2;
    tb_val    = 32'd7;
    tb_drv    = 1'b1;
    bus.probe = bus.probe ^ 3'b100;
    @(posedge clk);
    @(negedge clk);
    bus.le = 1'b1;
    tb_drv = 1'b0;
    read_cnt(2'd2, v);
    n_vec++;
    if (v !== 32'd7) begin
      n_err++;
      $display("FAIL coll_write_wins: got %0d want %0d", v, 7);
    end
    // History was updated during the write, so no late increment follows.
    @(negedge clk);
    read_cnt(2'd2, v);
    n_vec++;
    if (v !== 32'd7) begin
      n_err++;
      $display("FAIL coll_hist: got %0d want %0d", v, 7);
    end
  endtask

  task automatic test_saturation();
    cnt_t v;
    cnt_t obs;
    write_cnt(2'd0, 32'hFFFF_FFFE, obs);
    toggle(3'b001);
    @(negedge clk);
    read_cnt(2'd0, v);
    n_vec++;
    if (v !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL sat_reach: got %h want %h", v, 32'hFFFF_FFFF);
    end
    toggle(3'b001);
    toggle(3'b001);
    @(negedge clk);
    read_cnt(2'd0, v);
    n_vec++;
    if (v !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL sat_hold: got %h want %h", v, 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_multi_oob();
    cnt_t v;
    cnt_t obs;
    cnt_t exp_v [3];
    exp_v = '{32'hFFFF_FFFF, 32'd11, 32'd8};
    toggle(3'b111);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      read_cnt(2'(i), v);
      n_vec++;
      if (v !== exp_v[i]) begin
        n_err++;
        $display("FAIL multi_cnt%0d: got %h want %h", i, v, exp_v[i]);
      end
    end
    write_cnt(2'd3, 32'd55, obs);
    read_cnt(2'd3, v);
    n_vec++;
    if (v !== 32'd0) begin
      n_err++;
      $display("FAIL oob_read: got %h want %h", v, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      read_cnt(2'(i), v);
      n_vec++;
      if (v !== exp_v[i]) begin
        n_err++;
        $display("FAIL oob_keep%0d: got %h want %h", i, v, exp_v[i]);
      end
    end
  endtask

  task automatic test_le_midcycle();
    cnt_t v;
    @(negedge clk);
    bus.le  = 1'b0;
    bus.dir = 2'd1;
    tb_val  = 32'd999;
    tb_drv  = 1'b1;
    #2;
    bus.le = 1'b1;
    tb_drv = 1'b0;
    #1;
    v = dato;
    n_vec++;
    if (v !== 32'd11) begin
      n_err++;
      $display("FAIL le_rise_drive: got %0d want %0d", v, 11);
    end
    @(posedge clk);
    @(negedge clk);
    read_cnt(2'd1, v);
    n_vec++;
    if (v !== 32'd11) begin
      n_err++;
      $display("FAIL le_rise_nowrite: got %0d want %0d", v, 11);
    end
  endtask

  task automatic test_reset_mid();
    cnt_t v;
    toggle(3'b010);
    toggle(3'b010);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #2;
    bus.probe = 3'b010;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      read_cnt(2'(i), v);
      n_vec++;
      if (v !== 32'd0) begin
        n_err++;
        $display("FAIL rst_mid_cnt%0d: got %h want %h", i, v, 32'd0);
      end
    end
    toggle(3'b100);
    @(negedge clk);
    read_cnt(2'd2, v);
    n_vec++;
    if (v !== 32'd1) begin
      n_err++;
      $display("FAIL rearm_count: got %0d want %0d", v, 1);
    end
    read_cnt(2'd1, v);
    n_vec++;
    if (v !== 32'd0) begin
      n_err++;
      $display("FAIL rearm_quiet: got %0d want %0d", v, 0);
    end
  endtask

  initial begin
    test_reset();
    test_clear_write();
    test_toggle_count();
    test_collision();
    test_saturation();
    test_multi_oob();
    test_le_midcycle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
